vip_stream_pattern_gen: RTL and testbench

VIP_STREAM_PATTERN_GEN -- requirements
Module: vip_stream_pattern_gen

---
 rtl/vip_pkg.sv | 20 ++
 rtl/vip_pix_tick_div.sv | 30 +++
 rtl/vip_stream_pattern_gen.sv | 136 +++++++++++++
 tb/tb_vip_stream_pattern_gen.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vip_pkg.sv
// Shared types for the video pattern generator: FSM states, pattern codes, counter widths.
package vip_pkg;

  localparam int unsigned CNT_W       = 14;
  localparam int unsigned DIV_W       = 4;
  localparam int unsigned FRAME_CNT_W = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } vip_state_e;

  typedef enum logic [1:0] {
    PAT_HRAMP   = 2'd0,
    PAT_VRAMP   = 2'd1,
    PAT_CHECKER = 2'd2,
    PAT_FRAME   = 2'd3
  } vip_pattern_e;

endpackage

// File: rtl/vip_pix_tick_div.sv
// Pixel tick divider: one-cycle tick every CLKEN_DIV clocks while run is high.
module vip_pix_tick_div
  import vip_pkg::*;
#(
  parameter logic [DIV_W-1:0] CLKEN_DIV = 4'd2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic tick_c
);

  logic [DIV_W-1:0] div_cnt;
  logic             last_c;

  assign last_c = (div_cnt == (CLKEN_DIV - DIV_W'(1)));
  assign tick_c = run && last_c;

  // Held at zero outside RUN so the first tick of a frame is always CLKEN_DIV clocks in
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (!run || last_c) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/vip_stream_pattern_gen.sv
// Video stream test-pattern generator: raster counters, IDLE/RUN control and pixel patterns
// with registered vsync/href/clken/Y stream outputs.
module vip_stream_pattern_gen
  import vip_pkg::*;
#(
  parameter logic [12:0] IMG_HDISP = 13'd640,
  parameter logic [12:0] IMG_VDISP = 13'd480,
  parameter logic [12:0] H_BLANK   = 13'd160,
  parameter logic [12:0] V_BLANK   = 13'd45,
  parameter int unsigned VS_LINES  = 2,
  parameter logic [3:0]  CLKEN_DIV = 4'd2,
  parameter logic [4:0]  DATA_W    = 5'd8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [1:0]        pattern_sel,
  output logic              post_frame_vsync,
  output logic              post_frame_href,
  output logic              post_frame_clken,
  output logic [DATA_W-1:0] post_img_Y,
  output logic              frame_done,
  output logic              busy
);

  localparam int unsigned      PIX_W  = 32'(DATA_W);
  localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(IMG_HDISP);
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(IMG_HDISP) + CNT_W'(H_BLANK) - CNT_W'(1);
  localparam logic [CNT_W-1:0] V_ACT0 = CNT_W'(V_BLANK);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_BLANK) + CNT_W'(IMG_VDISP) - CNT_W'(1);
  localparam logic [CNT_W-1:0] VS_END = CNT_W'(VS_LINES);

  vip_state_e             state;
  vip_pattern_e           pattern_q;
  logic [CNT_W-1:0]       hcnt;
  logic [CNT_W-1:0]       vcnt;
  logic [FRAME_CNT_W-1:0] frame_cnt;

  logic             tick_c;
  logic             run_c;
  logic             line_end_c;
  logic             frame_end_c;
  logic             href_c;
  logic             vsync_c;
  logic             y_b3_c;
  logic [PIX_W-1:0] pix_c;

  assign run_c       = (state == ST_RUN);
  assign line_end_c  = (hcnt == H_LAST);
  assign frame_end_c = tick_c && line_end_c && (vcnt == V_LAST);
  assign href_c      = run_c && (vcnt >= V_ACT0) && (hcnt < H_ACT);
  assign vsync_c     = run_c && (vcnt < VS_END);
  assign y_b3_c      = (((vcnt - V_ACT0) & CNT_W'(8)) != '0);

  vip_pix_tick_div #(
    .CLKEN_DIV (CLKEN_DIV)
  ) u_tick_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .run    (run_c),
    .tick_c (tick_c)
  );

  // Pixel value for the current raster position; y is the active-line index
  always_comb begin
    pix_c = '0;
    case (pattern_q)
      PAT_HRAMP:   pix_c = PIX_W'(hcnt);
      PAT_VRAMP:   pix_c = PIX_W'(vcnt - V_ACT0);
      PAT_CHECKER: pix_c = (hcnt[3] ^ y_b3_c) ? '1 : '0;
      PAT_FRAME:   pix_c = PIX_W'(frame_cnt);
      default:     pix_c = '0;
    endcase
  end

  // Control FSM with raster counters; enable is only consulted on the last tick of a frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      hcnt      <= '0;
      vcnt      <= '0;
      pattern_q <= PAT_HRAMP;
      frame_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          hcnt <= '0;
          vcnt <= '0;
          if (enable) begin
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (tick_c) begin
            if ((hcnt == '0) && (vcnt == '0)) begin
              pattern_q <= vip_pattern_e'(pattern_sel);
            end
            if (line_end_c) begin
              hcnt <= '0;
              vcnt <= (vcnt == V_LAST) ? '0 : vcnt + CNT_W'(1);
            end else begin
              hcnt <= hcnt + CNT_W'(1);
            end
            if (frame_end_c) begin
              frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
              if (!enable) begin
                state <= ST_IDLE;
              end
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Stream outputs: one register stage behind the counters, all aligned
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      post_frame_vsync <= 1'b0;
      post_frame_href  <= 1'b0;
      post_frame_clken <= 1'b0;
      post_img_Y       <= '0;
      frame_done       <= 1'b0;
      busy             <= 1'b0;
    end else begin
      post_frame_vsync <= vsync_c;
      post_frame_href  <= href_c;
      post_frame_clken <= tick_c && href_c;
      post_img_Y       <= href_c ? pix_c : '0;
      frame_done       <= frame_end_c;
      busy             <= run_c;
    end
  end

endmodule

// File: tb/tb_vip_stream_pattern_gen.sv
// Directed bench for vip_stream_pattern_gen: small raster (8x4) plus a 32-wide instance for the checkerboard.
module tb_vip_stream_pattern_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable_a = 1'b0;
  logic       enable_b = 1'b0;
  logic [1:0] pattern_sel_a = 2'd0;
  logic [1:0] pattern_sel_b = 2'd0;

  logic       vsync_a, href_a, clken_a, frame_done_a, busy_a;
  logic [7:0] y_a;
  logic       vsync_b, href_b, clken_b, frame_done_b, busy_b;
  logic [7:0] y_b;

  int n_cmp = 0;
  int n_bad = 0;

  // Monitor state (written only by the monitor process)
  int         cyc = 0;
  int         clk_fr = 0;
  int         vs_fr = 0;
  int         href_fr = 0;
  int         fd_cyc[$];
  int         fr_clken[$];
  int         fr_vs[$];
  int         fr_href[$];
  logic [7:0] pix_a[$];
  logic [7:0] pix_b[$];

  always #5 clk = ~clk;

  vip_stream_pattern_gen #(
    .IMG_HDISP (13'd8),
    .IMG_VDISP (13'd4),
    .H_BLANK   (13'd4),
    .V_BLANK   (13'd3),
    .VS_LINES  (1),
    .CLKEN_DIV (4'd2),
    .DATA_W    (5'd8)
  ) u_dut_a (
    .clk              (clk),
    .rst_n            (rst_n),
    .enable           (enable_a),
    .pattern_sel      (pattern_sel_a),
    .post_frame_vsync (vsync_a),
    .post_frame_href  (href_a),
    .post_frame_clken (clken_a),
    .post_img_Y       (y_a),
    .frame_done       (frame_done_a),
    .busy             (busy_a)
  );

  vip_stream_pattern_gen #(
    .IMG_HDISP (13'd32),
    .IMG_VDISP (13'd4),
    .H_BLANK   (13'd4),
    .V_BLANK   (13'd3),
    .VS_LINES  (1),
    .CLKEN_DIV (4'd2),
    .DATA_W    (5'd8)
  ) u_dut_b (
    .clk              (clk),
    .rst_n            (rst_n),
    .enable           (enable_b),
    .pattern_sel      (pattern_sel_b),
    .post_frame_vsync (vsync_b),
    .post_frame_href  (href_b),
    .post_frame_clken (clken_b),
    .post_img_Y       (y_b),
    .frame_done       (frame_done_b),
    .busy             (busy_b)
  );

  // Collect pixels on clken and per-frame statistics of instance A, closed on frame_done
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) begin
      clk_fr  <= 0;
      vs_fr   <= 0;
      href_fr <= 0;
    end else begin
      if (clken_a) pix_a.push_back(y_a);
      if (clken_b) pix_b.push_back(y_b);
      if (frame_done_a) begin
        fr_clken.push_back(clk_fr);
        fr_vs.push_back(vs_fr);
        fr_href.push_back(href_fr);
        fd_cyc.push_back(cyc);
        clk_fr  <= 0;
        vs_fr   <= 0;
        href_fr <= 0;
      end else begin
        clk_fr  <= clk_fr + (clken_a ? 1 : 0);
        vs_fr   <= vs_fr + (vsync_a ? 1 : 0);
        href_fr <= href_fr + (href_a ? 1 : 0);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(3);
    n_cmp++;
    if ({vsync_a, href_a, clken_a, frame_done_a, busy_a, y_a,
         vsync_b, href_b, clken_b, frame_done_b, busy_b, y_b} !== 26'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got a=%b%b%b%b%b y=%h b=%b%b%b%b%b y=%h, want all 0",
               vsync_a, href_a, clken_a, frame_done_a, busy_a, y_a,
               vsync_b, href_b, clken_b, frame_done_b, busy_b, y_b);
    end
    rst_n = 1'b1;
    step(6);
    n_cmp++;
    if ({vsync_a, href_a, clken_a, busy_a} !== 4'b0000) begin
      n_bad++;
      $display("FAIL idle_hold: got vsync=%b href=%b clken=%b busy=%b, want 0000",
               vsync_a, href_a, clken_a, busy_a);
    end
  endtask

  task automatic test_pattern_ramp();
    int base;
    int fd0;
    base = pix_a.size();
    fd0  = fd_cyc.size();
    pattern_sel_a = 2'd0;
    enable_a      = 1'b1;
    for (int i = 0; i < 400 && pix_a.size() < base + 10; i++) step(1);
    pattern_sel_a = 2'd3;
    for (int i = 0; i < 400 && fd_cyc.size() < fd0 + 1; i++) step(1);
    n_cmp++;
    if (fd_cyc.size() != fd0 + 1) begin
      n_bad++;
      $display("FAIL ramp_frame_done: got %0d frame_done pulses, want 1", fd_cyc.size() - fd0);
      return;
    end
    n_cmp++;
    if (fr_clken[fd0] != 32) begin
      n_bad++;
      $display("FAIL ramp_clken_count: got %0d, want 32", fr_clken[fd0]);
    end
    n_cmp++;
    if (fr_vs[fd0] != 24) begin
      n_bad++;
      $display("FAIL ramp_vsync_clks: got %0d, want 24", fr_vs[fd0]);
    end
    n_cmp++;
    if (fr_href[fd0] != 64) begin
      n_bad++;
      $display("FAIL ramp_href_clks: got %0d, want 64", fr_href[fd0]);
    end
    n_cmp++;
    if (pix_a.size() != base + 32) begin
      n_bad++;
      $display("FAIL ramp_pixel_count: got %0d, want 32", pix_a.size() - base);
      return;
    end
    for (int i = 0; i < 32; i++) begin
      n_cmp++;
      if (pix_a[base + i] !== 8'(i % 8)) begin
        n_bad++;
        $display("FAIL ramp_pixel[%0d]: got %h, want %h", i, pix_a[base + i], 8'(i % 8));
      end
    end
  endtask

  task automatic test_back_to_back();
    int base;
    int fd0;
    base = pix_a.size();
    fd0  = fd_cyc.size();
    for (int i = 0; i < 400 && pix_a.size() < base + 1; i++) step(1);
    pattern_sel_a = 2'd1;
    for (int i = 0; i < 400 && fd_cyc.size() < fd0 + 1; i++) step(1);
    n_cmp++;
    if (fd0 < 1 || fd_cyc.size() != fd0 + 1) begin
      n_bad++;
      $display("FAIL b2b_frame_done: got %0d pulses after %0d frames, want 1", fd_cyc.size() - fd0, fd0);
      return;
    end
    n_cmp++;
    if (fd_cyc[fd0] - fd_cyc[fd0 - 1] != 168) begin
      n_bad++;
      $display("FAIL b2b_frame_period: got %0d clk, want 168", fd_cyc[fd0] - fd_cyc[fd0 - 1]);
    end
    n_cmp++;
    if (fr_clken[fd0] != 32 || fr_vs[fd0] != 24) begin
      n_bad++;
      $display("FAIL b2b_counts: got clken=%0d vsync=%0d, want 32 24", fr_clken[fd0], fr_vs[fd0]);
    end
    n_cmp++;
    if (busy_a !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_busy: got %b, want 1", busy_a);
    end
    for (int i = 0; i < 32 && base + i < pix_a.size(); i++) begin
      n_cmp++;
      if (pix_a[base + i] !== 8'd1) begin
        n_bad++;
        $display("FAIL framecnt_pixel[%0d]: got %h, want 01", i, pix_a[base + i]);
      end
    end
  endtask

  task automatic test_enable_drop();
    int  base;
    int  fd0;
    logic seen;
    base = pix_a.size();
    fd0  = fd_cyc.size();
    for (int i = 0; i < 400 && pix_a.size() < base + 5; i++) step(1);
    enable_a = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      step(1);
      seen = frame_done_a;
    end
    n_cmp++;
    if (!seen) begin
      n_bad++;
      $display("FAIL drop_frame_done: got no pulse, want one");
      return;
    end
    n_cmp++;
    if (busy_a !== 1'b1) begin
      n_bad++;
      $display("FAIL drop_busy_at_done: got %b, want 1", busy_a);
    end
    step(1);
    n_cmp++;
    if ({frame_done_a, busy_a} !== 2'b00) begin
      n_bad++;
      $display("FAIL drop_after_done: got frame_done=%b busy=%b, want 0 0", frame_done_a, busy_a);
    end
    n_cmp++;
    if (fd_cyc[fd0] - fd_cyc[fd0 - 1] != 168) begin
      n_bad++;
      $display("FAIL drop_frame_period: got %0d clk, want 168", fd_cyc[fd0] - fd_cyc[fd0 - 1]);
    end
    for (int i = 0; i < 32 && base + i < pix_a.size(); i++) begin
      n_cmp++;
      if (pix_a[base + i] !== 8'(i / 8)) begin
        n_bad++;
        $display("FAIL vramp_pixel[%0d]: got %h, want %h", i, pix_a[base + i], 8'(i / 8));
      end
    end
    step(200);
    n_cmp++;
    if (fd_cyc.size() != fd0 + 1 || {busy_a, vsync_a} !== 2'b00) begin
      n_bad++;
      $display("FAIL drop_stays_idle: got pulses=%0d busy=%b vsync=%b, want 1 0 0",
               fd_cyc.size() - fd0, busy_a, vsync_a);
    end
  endtask

  task automatic test_reset_mid();
    int base;
    int base2;
    logic seen;
    base = pix_a.size();
    pattern_sel_a = 2'd0;
    enable_a      = 1'b1;
    for (int i = 0; i < 400 && pix_a.size() < base + 19; i++) step(1);
    n_cmp++;
    if (pix_a.size() < base + 19 || href_a !== 1'b1 || pix_a[base + 18] !== 8'd2) begin
      n_bad++;
      $display("FAIL midrst_line2: got pixels=%0d href=%b, want >=19 1", pix_a.size() - base, href_a);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({vsync_a, href_a, clken_a, frame_done_a, busy_a, y_a} !== 13'd0) begin
      n_bad++;
      $display("FAIL midrst_outputs: got %b%b%b%b%b y=%h, want all 0",
               vsync_a, href_a, clken_a, frame_done_a, busy_a, y_a);
    end
    step(2);
    pattern_sel_a = 2'd3;
    base2 = pix_a.size();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step(1);
      seen = vsync_a | href_a;
    end
    n_cmp++;
    if ({vsync_a, href_a} !== 2'b10) begin
      n_bad++;
      $display("FAIL midrst_restart: got vsync=%b href=%b, want 1 0", vsync_a, href_a);
    end
    for (int i = 0; i < 400 && pix_a.size() < base2 + 1; i++) step(1);
    n_cmp++;
    if (pix_a.size() < base2 + 1 || pix_a[base2] !== 8'd0) begin
      n_bad++;
      $display("FAIL midrst_frame_cnt: got pixels=%0d first=%h, want frame_cnt 00",
               pix_a.size() - base2, (pix_a.size() > base2) ? pix_a[base2] : 8'hxx);
    end
    enable_a = 1'b0;
  endtask

  task automatic test_checker();
    int idx[6] = '{0, 7, 8, 16, 24, 40};
    logic [7:0] exp[6] = '{8'h00, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'hFF};
    pattern_sel_b = 2'd2;
    enable_b      = 1'b1;
    for (int i = 0; i < 600 && pix_b.size() < 41; i++) step(1);
    n_cmp++;
    if (pix_b.size() < 41) begin
      n_bad++;
      $display("FAIL checker_pixels: got %0d, want >=41", pix_b.size());
      return;
    end
    for (int k = 0; k < 6; k++) begin
      n_cmp++;
      if (pix_b[idx[k]] !== exp[k]) begin
        n_bad++;
        $display("FAIL checker_pixel[%0d]: got %h, want %h", idx[k], pix_b[idx[k]], exp[k]);
      end
    end
    enable_b = 1'b0;
  endtask

  initial begin
    test_reset();
    test_pattern_ramp();
    test_back_to_back();
    test_enable_drop();
    test_reset_mid();
    test_checker();
    step(4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
